key_loader: RTL and testbench

KEY_LOADER -- requirements
Module: key_loader

---
 rtl/key_loader_pkg.sv | 19 +
 rtl/key_loader_if.sv | 24 ++
 rtl/key_loader.sv | 111 +++++++++++
 tb/tb_key_loader.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/key_loader_pkg.sv
// Shared types and constants for the serial key loader.
// State encodings are plain localparams so older code can compare against raw values.
package key_loader_pkg;

    localparam int KEY_W_DEFAULT = 64;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_loader_if.sv
// Control, serial key stream and committed-key bundle between the key source and the loader.
interface key_loader_if import key_loader_pkg::*; #(
    parameter int KEY_W = KEY_W_DEFAULT
);
    logic             load_start;
    logic             zeroize;
    logic             ser_valid;
    logic             ser_data;
    logic             ser_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             busy;
    logic             err;

    modport master (
        output load_start, zeroize, ser_valid, ser_data,
        input  ser_ready, key_out, key_valid, busy, err
    );

    modport slave (
        input  load_start, zeroize, ser_valid, ser_data,
        output ser_ready, key_out, key_valid, busy, err
    );
endinterface

// File: rtl/key_loader.sv
// Shifts a key in LSB first and commits it atomically to key_out for the locked netlist.
// Define KEY_PARITY_EN to require a trailing even-parity beat before commit.
module key_loader import key_loader_pkg::*; #(
    parameter int KEY_W = KEY_W_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    key_loader_if.slave bus
);
    localparam int CW = $clog2(KEY_W + 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [KEY_W-1:0] shadow;
    logic [KEY_W-1:0] shadow_nxt;
    logic [KEY_W-1:0] key_q;
    logic             key_valid_q;
    logic             beat;
    logic             last_bit;
    logic             start_ok;

`ifdef KEY_PARITY_EN
    assign bus.ser_ready = (state == S_SHIFT) || (state == S_CHECK);
`else
    assign bus.ser_ready = (state == S_SHIFT);
`endif
    assign bus.busy      = bus.ser_ready;
    assign bus.key_out   = key_q;
    assign bus.key_valid = key_valid_q;

    assign beat     = bus.ser_valid && bus.ser_ready;
    assign last_bit = (cnt == CW'(KEY_W - 1));
    assign start_ok = bus.load_start && ((state == S_IDLE) || (state == S_DONE));
    // shadow is cleared at load start, so OR-ing the new bit in is a write to bit cnt
    assign shadow_nxt = shadow | (KEY_W'(bus.ser_data) << cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shadow      <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else if (bus.zeroize) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shadow      <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.load_start) begin
                        state       <= S_SHIFT;
                        cnt         <= '0;
                        shadow      <= '0;
                        key_valid_q <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (beat) begin
                        shadow <= shadow_nxt;
                        cnt    <= cnt + CW'(1);
                        if (last_bit) begin
`ifdef KEY_PARITY_EN
                            state <= S_CHECK;
`else
                            state       <= S_DONE;
                            key_q       <= shadow_nxt;
                            key_valid_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef KEY_PARITY_EN
                S_CHECK: begin
                    if (beat) begin
                        if (bus.ser_data == ^shadow) begin
                            state       <= S_DONE;
                            key_q       <= shadow;
                            key_valid_q <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef KEY_PARITY_EN
    logic err_q;

    // sticky until the next accepted load_start, zeroize or reset
    always_ff @(posedge clk) begin
        if (rst || bus.zeroize)
            err_q <= 1'b0;
        else if (start_ok)
            err_q <= 1'b0;
        else if ((state == S_CHECK) && beat && (bus.ser_data != ^shadow))
            err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: scoreboard of committed keys, zeroize/reset aborts,
// ignored restarts and (with KEY_PARITY_EN) the parity accept/reject paths.
module tb_key_loader;
    import key_loader_pkg::*;

    localparam int KEY_W = KEY_W_DEFAULT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_loader_if #(.KEY_W(KEY_W)) bus ();
    key_loader #(.KEY_W(KEY_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    logic [KEY_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [KEY_W-1:0] got, input logic [KEY_W-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops the scoreboard when the DUT presents a committed key.
    task automatic commit_check(input string tag);
        logic [KEY_W-1:0] e;
        chk1({tag, "_kv"}, bus.key_valid, 1'b1);
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk({tag, "_key"}, bus.key_out, e);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    // One full load with random valid gaps; optional restart, zeroize or reset at a given beat.
    task automatic run_load(input logic [KEY_W-1:0] key, input logic par,
                            input int ld_at, input int zz_at, input int rs_at);
        logic [KEY_W-1:0] prev;
        logic stable;
        prev   = bus.key_out;
        stable = 1'b1;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        chk1("start_busy", bus.busy, 1'b1);
        chk1("start_kv_drop", bus.key_valid, 1'b0);
        for (int n = 0; n < KEY_W; n++) begin
            bus.ser_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            bus.ser_valid  = 1'b1;
            bus.ser_data   = key[n];
            bus.load_start = (n == ld_at);
            bus.zeroize    = (n == zz_at);
            rst            = (n == rs_at);
            if (bus.key_out !== prev) stable = 1'b0;
`ifndef KEY_PARITY_EN
            if (n == KEY_W - 1) chk1("kv_before_last", bus.key_valid, 1'b0);
`endif
            tick();
            bus.load_start = 1'b0;
            bus.zeroize    = 1'b0;
            rst            = 1'b0;
            if (n == zz_at || n == rs_at) begin
                bus.ser_valid = 1'b0;
                chk1("stable_until_abort", stable, 1'b1);
                return;
            end
        end
`ifdef KEY_PARITY_EN
        bus.ser_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        bus.ser_valid = 1'b1;
        bus.ser_data  = par;
        if (bus.key_out !== prev) stable = 1'b0;
        chk1("kv_before_parity", bus.key_valid, 1'b0);
        tick();
`endif
        bus.ser_valid = 1'b0;
        chk1("key_stable_during_load", stable, 1'b1);
    endtask

    localparam logic [KEY_W-1:0] K1 = 64'hA5A5_0F0F_1234_5678;
    localparam logic [KEY_W-1:0] K2 = 64'h0123_4567_89AB_CDEF;
    localparam logic [KEY_W-1:0] K3 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [KEY_W-1:0] K4 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.zeroize    = 1'b0;
        bus.ser_valid  = 1'b0;
        bus.ser_data   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_key", bus.key_out, '0);
        chk1("rst_kv", bus.key_valid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chk1("rst_ready", bus.ser_ready, 1'b0);

        // plain load with gaps; commit one cycle after the last beat
        exp_q.push_back(K1);
        run_load(K1, ^K1, -1, -1, -1);
        commit_check("t1");
        chk1("t1_ready", bus.ser_ready, 1'b0);
        repeat (3) tick();
        chk1("done_hold_kv", bus.key_valid, 1'b1);
        chk("done_hold_key", bus.key_out, K1);

        // restart pulse at beat 30 must be ignored
        exp_q.push_back(K2);
        run_load(K2, ^K2, 30, -1, -1);
        commit_check("t2");

        // zeroize at beat 40 aborts and clears
        run_load(K3, ^K3, -1, 40, -1);
        chk("zz_key", bus.key_out, '0);
        chk1("zz_kv", bus.key_valid, 1'b0);
        chk1("zz_busy", bus.busy, 1'b0);
        chk1("zz_err", bus.err, 1'b0);
        bus.ser_valid = 1'b1;
        bus.ser_data  = 1'b1;
        repeat (3) tick();
        chk1("zz_no_accept", bus.ser_ready, 1'b0);
        chk("zz_key_after", bus.key_out, '0);
        bus.ser_valid = 1'b0;

        // reset at beat 10 after an all-ones key
        exp_q.push_back(K4);
        run_load(K4, ^K4, -1, -1, -1);
        commit_check("t4");
        run_load(K1, ^K1, -1, -1, 10);
        chk("rst_mid_key", bus.key_out, '0);
        chk1("rst_mid_kv", bus.key_valid, 1'b0);
        chk1("rst_mid_busy", bus.busy, 1'b0);
        chk1("rst_mid_ready", bus.ser_ready, 1'b0);
        chk1("rst_mid_err", bus.err, 1'b0);

        // simultaneous load_start and zeroize resolves as zeroize
        exp_q.push_back(K2);
        run_load(K2, ^K2, -1, -1, -1);
        commit_check("t5");
        bus.load_start = 1'b1;
        bus.zeroize    = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.zeroize    = 1'b0;
        chk1("both_busy", bus.busy, 1'b0);
        chk("both_key", bus.key_out, '0);
        chk1("both_kv", bus.key_valid, 1'b0);

`ifdef KEY_PARITY_EN
        exp_q.push_back(64'h1);
        run_load(64'h1, 1'b1, -1, -1, -1);
        commit_check("par_ok");
        chk1("par_ok_err", bus.err, 1'b0);
        run_load(64'h1, 1'b0, -1, -1, -1);
        chk1("par_bad_err", bus.err, 1'b1);
        chk1("par_bad_kv", bus.key_valid, 1'b0);
        chk("par_bad_key", bus.key_out, 64'h1);
        chk1("par_bad_busy", bus.busy, 1'b0);
        repeat (2) tick();
        chk1("par_err_sticky", bus.err, 1'b1);
`else
        chk1("err_tied_low", bus.err, 1'b0);
`endif

        chk1("sb_drained", exp_q.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
